uart_rx_frame: RTL

Asynchronous-serial receive stage sitting directly downstream of `baud_rate_gen`. It consumes the generator's oversampling tick and the raw `rx` line. It detects and validates start bits, samples each bit at mid-bit, and assembles LSB-first data words. Words are delivered to the core over a valid/ready handshake, and framing and overrun errors are reported.

---
 rtl/uart_rx_frame_if.sv | 28 ++
 rtl/uart_rx_frame.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_if.sv
// Receive-side bundle between the baud generator, the serial line and the word consumer.
// Latency: none (wiring only).
// Backpressure: rx_valid/rx_ready; the receiver reports lost words with overrun_err.
// Ports: master = receiver (drives baud_en, rx_data, rx_valid, error pulses);
//        slave  = environment (drives baud_tick, rx, rx_ready).
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_tick;
  logic                 rx;
  logic                 baud_en;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 framing_err;
  logic                 overrun_err;
  logic                 parity_err;

  modport master (
    input  baud_tick, rx, rx_ready,
    output baud_en, rx_data, rx_valid, framing_err, overrun_err, parity_err
  );

  modport slave (
    output baud_tick, rx, rx_ready,
    input  baud_en, rx_data, rx_valid, framing_err, overrun_err, parity_err
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive framer: start-bit validation, mid-bit sampling, LSB-first word assembly.
// Latency: outputs register one clk after the stop-bit sample; rx to START entry 2-3 clk.
// Backpressure: one-word output register; a word arriving while it is unaccepted is dropped with overrun_err.
// Ports: clk, areset (async, active high), bus (uart_rx_frame_if.master: baud_tick, rx,
//        rx_ready in; baud_en, rx_data, rx_valid, framing_err, overrun_err, parity_err out).
// Optional macro UART_RX_PARITY_EN adds an even-parity bit after the data bits.
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              areset,
  uart_rx_frame_if.master   bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  // Terminal counts: the sample happens on the tick that completes the interval.
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 sync0_q, rxs_q;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 baud_en_q, baud_en_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sync0_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync0_q <= bus.rx;
      rxs_q   <= sync0_q;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      shreg_q    <= '0;
      baud_en_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      oerr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      baud_en_q  <= baud_en_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
      oerr_q     <= oerr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
      perr_q     <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    // An accepted word leaves the output register unless a new one replaces it below.
    rx_valid_d = rx_valid_q && !bus.rx_ready;
    ferr_d     = 1'b0;
    oerr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    perr_d     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // Ticks are ignored here; the counters restart from the detection point.
        tcnt_d = '0;
        bcnt_d = '0;
        if (!rxs_q) state_d = S_START;
      end

      S_START: begin
        if (bus.baud_tick) begin
          if (tcnt_q == T_HALF) begin
            tcnt_d  = '0;
            state_d = rxs_q ? S_IDLE : S_DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (bus.baud_tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d          = '0;
            shreg_d[bcnt_q] = rxs_q;
            if (bcnt_q == B_LAST) begin
              bcnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bus.baud_tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d    = '0;
            // Even parity: data bits plus parity bit must XOR to zero.
            par_bad_d = ^{shreg_q, rxs_q};
            state_d   = S_STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`endif

      S_STOP: begin
        if (bus.baud_tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d  = '0;
            state_d = S_IDLE;
            if (rxs_q) begin
              if (!rx_valid_q || bus.rx_ready) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
              end else begin
                oerr_d = 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              perr_d = par_bad_q;
`endif
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered from the next state so it rises on START entry and falls on the stop/false-start edge.
    baud_en_d = (state_d != S_IDLE);
  end

  assign bus.baud_en     = baud_en_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.framing_err = ferr_q;
  assign bus.overrun_err = oerr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err  = perr_q;
`else
  assign bus.parity_err  = 1'b0;
`endif

endmodule
